// File: rtl/cam_pix_cap.sv
// cam_pix_cap: camera pixel capture stage.
//   Samples an 8-bit RGB565 byte stream framed by VSYNC/HREF, pairs bytes
//   into pixels, expands them to RGB888 (zero-padded to 32 bits), and queues
//   them in a show-ahead FIFO drained by a valid/ready handshake.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   cap_en                arm capture (only looked at on a vsync fall in IDLE)
//   cam_vsync/href/data   camera stream, synchronous to clk
//   pix_data/valid/rdy    downstream pixel handshake, {8'h00,R8,G8,B8}
//   frame_start/done      one-cycle frame boundary pulses
//   line_err/frame_err    sticky framing errors
//   overflow/drop_cnt     sticky FIFO-full drop flag and saturating drop count
module cam_pix_cap #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FIFO_AW  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_rdy,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic        overflow,
    output logic [15:0] drop_cnt
);
    localparam int CW    = $clog2(H_ACTIVE + 2);
    localparam int RW    = $clog2(V_ACTIVE + 1);
    localparam int DEPTH = 2 ** FIFO_AW;

    // S_LO holds byte0 and waits for byte1; S_HI waits for the next byte0.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_LO   = 2'd3;

    logic [1:0]    state;
    logic          vsync_r, vsync_rr, href_r, href_rr;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    byte0;
    logic [31:0]   px_word;
    logic          px_push;

    logic vs_fall, vs_rise, hr_fall;
    assign vs_fall = vsync_rr & ~vsync_r;
    assign vs_rise = ~vsync_rr & vsync_r;
    assign hr_fall = href_rr & ~href_r;

    function automatic logic [31:0] expand(input logic [7:0] b0, input logic [7:0] b1);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = b0[7:3];
        g6 = {b0[2:0], b1[7:5]};
        b5 = b1[4:0];
        return {8'h00, r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    // Capture FSM. cam_data is used unregistered; it lines up with the
    // registered href, so the camera presents href one clk ahead of byte0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            vsync_r     <= 1'b0;
            vsync_rr    <= 1'b0;
            href_r      <= 1'b0;
            href_rr     <= 1'b0;
            col         <= '0;
            row         <= '0;
            byte0       <= 8'h00;
            px_word     <= 32'h0;
            px_push     <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vsync_r     <= cam_vsync;
            vsync_rr    <= vsync_r;
            href_r      <= cam_href;
            href_rr     <= href_r;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            px_push     <= 1'b0;
            if (state == S_IDLE) begin
                if (vs_fall && cap_en) begin
                    frame_start <= 1'b1;
                    col         <= '0;
                    row         <= '0;
                    state       <= S_WAIT;
                end
            end else if (vs_rise) begin
                // Aborted frame: any half pixel in byte0 is simply never pushed.
                frame_err <= 1'b1;
                state     <= S_IDLE;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (href_r) begin
                            byte0 <= cam_data;
                            state <= S_LO;
                        end
                    end
                    default: begin
                        if (hr_fall) begin
                            if (col != CW'(H_ACTIVE) || state == S_LO)
                                line_err <= 1'b1;
                            col <= '0;
                            row <= row + RW'(1);
                            if (row == RW'(V_ACTIVE - 1)) begin
                                frame_done <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else if (state == S_HI) begin
                            byte0 <= cam_data;
                            state <= S_LO;
                        end else begin
                            px_word <= expand(byte0, cam_data);
                            px_push <= 1'b1;
                            // Saturate one past H_ACTIVE so long lines still flag.
                            if (col != CW'(H_ACTIVE + 1))
                                col <= col + CW'(1);
                            state <= S_HI;
                        end
                    end
                endcase
            end
        end
    end

    // FIFO: mem holds every queued pixel, including the one mirrored in the
    // registered head (pix_data), so capacity is exactly DEPTH.
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wp, rp, rp_nxt;
    logic [FIFO_AW:0]   cnt, cnt_left;
    logic               pop, full, wr, drop;

    assign pop      = pix_valid & pix_rdy;
    assign full     = (cnt == DEPTH[FIFO_AW:0]);
    assign wr       = px_push & (~full | pop);
    assign drop     = px_push & full & ~pop;
    assign rp_nxt   = rp + FIFO_AW'(pop);
    assign cnt_left = cnt - (FIFO_AW + 1)'(pop);

    always_ff @(posedge clk) begin
        if (wr)
            mem[wp] <= px_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            pix_valid <= 1'b0;
            pix_data  <= 32'h0;
            overflow  <= 1'b0;
            drop_cnt  <= 16'h0;
        end else begin
            if (wr)
                wp <= wp + FIFO_AW'(1);
            rp <= rp_nxt;
            case ({wr, pop})
                2'b10:   cnt <= cnt + (FIFO_AW + 1)'(1);
                2'b01:   cnt <= cnt - (FIFO_AW + 1)'(1);
                default: cnt <= cnt;
            endcase
            // Head only presents entries already in mem: a word written this
            // edge becomes visible one edge later.
            pix_valid <= (cnt_left != '0);
            if (cnt_left != '0)
                pix_data <= mem[rp_nxt];
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_cam_pix_cap.sv
module tb_cam_pix_cap;
    logic        clk;
    logic        reset;
    logic        cap_en;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_rdy;
    logic        frame_start;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;
    logic        overflow;
    logic [15:0] drop_cnt;

    cam_pix_cap #(.H_ACTIVE(4), .V_ACTIVE(2), .FIFO_AW(3)) dut (
        .clk(clk), .reset(reset), .cap_en(cap_en),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_rdy(pix_rdy),
        .frame_start(frame_start), .frame_done(frame_done),
        .line_err(line_err), .frame_err(frame_err),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    int          n_fs = 0;
    int          n_fd = 0;
    int          rdy_mode = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  lb [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference pixel: RGB565 fields widened by replicating their top bits.
    function automatic logic [31:0] px_model(input logic [7:0] b0, input logic [7:0] b1);
        int r5, g6, bb5, r8, g8, b8;
        r5  = int'(b0) / 8;
        g6  = (int'(b0) % 8) * 8 + int'(b1) / 32;
        bb5 = int'(b1) % 32;
        r8  = r5 * 8 + r5 / 4;
        g8  = g6 * 4 + g6 / 16;
        b8  = bb5 * 8 + bb5 / 4;
        return 32'(r8 * 65536 + g8 * 256 + b8);
    endfunction

    // Ready pattern changes just after posedge; monitor looks at negedge.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       pix_rdy = 1'b0;
            1:       pix_rdy = 1'b1;
            default: pix_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!reset && pix_valid && pix_rdy) begin
            n_pop++;
            if (exp_q.size() == 0) chk("pix_extra", exp_q.size(), 1);
            else                   chk("pix_data", pix_data, exp_q.pop_front());
        end
        if (frame_start) n_fs++;
        if (frame_done)  n_fd++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic vs_frame(input bit en);
        @(negedge clk); cam_vsync = 1'b1; cap_en = en;
        repeat (3) @(negedge clk);
        cam_vsync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("frame_start", frame_start, en);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) lb[i] = 8'($urandom);
    endtask

    task automatic push_model(input int n, input int maxpx);
        for (int i = 0; i + 1 < n && i / 2 < maxpx; i += 2)
            exp_q.push_back(px_model(lb[i], lb[i + 1]));
    endtask

    // href leads the bytes by one clk; returns before the href-fall edge.
    task automatic drive_line(input int n, input bit probe);
        for (int j = 0; j <= n + 1; j++) begin
            @(negedge clk);
            if (probe && j == 4) chk("lat_n2", pix_valid, 0);
            if (probe && j == 5) chk("lat_n3", pix_valid, 1);
            cam_href = (j < n);
            cam_data = (j >= 1 && j <= n) ? lb[j - 1] : 8'h00;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("empty_after", pix_valid, 0);
    endtask

    initial begin
        int fd0, pop0;
        reset = 1'b1; cap_en = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
        pix_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_fstart", frame_start, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_errs", {line_err, frame_err, overflow}, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b0;

        // Directed 4x2 frame with known colour pairs.
        rdy_mode = 1;
        fd0 = n_fd;
        vs_frame(1);
        lb[0] = 8'hF8; lb[1] = 8'h00; lb[2] = 8'h07; lb[3] = 8'hE0;
        lb[4] = 8'h00; lb[5] = 8'h1F; lb[6] = 8'h84; lb[7] = 8'h10;
        exp_q.push_back(32'h00FF0000); exp_q.push_back(32'h0000FF00);
        exp_q.push_back(32'h000000FF); exp_q.push_back(32'h00848284);
        drive_line(8, 1);
        @(negedge clk);
        chk("done_row0", frame_done, 0);
        for (int i = 0; i < 8; i += 2) begin lb[i] = 8'hF8; lb[i + 1] = 8'h00; end
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h00FF0000);
        drive_line(8, 0);
        @(negedge clk);
        chk("done_pulse", frame_done, 1);
        @(negedge clk);
        chk("done_len", frame_done, 0);
        wait_drain();
        chk("t1_errs", {line_err, frame_err, overflow}, 0);
        chk("t1_ndone", n_fd - fd0, 1);

        // Full frame held back: 8 pixels fit exactly.
        rdy_mode = 0;
        vs_frame(1);
        fill_rand(8); push_model(8, 8); drive_line(8, 0);
        fill_rand(8); push_model(8, 8); drive_line(8, 0);
        repeat (4) @(negedge clk);
        chk("t2_ovf", overflow, 0);
        chk("t2_valid", pix_valid, 1);
        pop0 = n_pop;
        rdy_mode = 1;
        wait_drain();
        chk("t2_npop", n_pop - pop0, 8);

        // 10-pixel line into an 8-deep FIFO: two drops, order preserved.
        rdy_mode = 0;
        vs_frame(1);
        fill_rand(20); push_model(20, 8); drive_line(20, 0);
        repeat (4) @(negedge clk);
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_cnt, 2);
        chk("t3_lerr", line_err, 1);
        rdy_mode = 1;
        wait_drain();
        fill_rand(8); push_model(8, 8); drive_line(8, 0);
        @(negedge clk);
        chk("t3_done", frame_done, 1);
        wait_drain();
        chk("t3_drop_kept", drop_cnt, 2);

        // Reset mid-line with 3 pixels queued.
        rdy_mode = 0;
        vs_frame(1);
        fill_rand(6); drive_line(6, 0);
        @(negedge clk); cam_href = 1'b1;
        @(negedge clk); cam_data = 8'h12;
        @(negedge clk); cam_data = 8'h34;
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        exp_q.delete();
        chk("mr_valid", pix_valid, 0);
        chk("mr_flags", {line_err, frame_err, overflow, frame_start, frame_done}, 0);
        chk("mr_drop", drop_cnt, 0);
        fd0 = n_fd; pop0 = n_pop;
        for (int i = 0; i < 6; i++) begin @(negedge clk); cam_data = 8'($urandom); end
        cam_href = 1'b0;
        rdy_mode = 1;
        repeat (10) @(negedge clk);
        chk("mr_nocap", n_pop - pop0, 0);
        chk("mr_nodone", n_fd - fd0, 0);

        // Short line, then odd byte count with half pixel discarded.
        vs_frame(1);
        fill_rand(6); push_model(6, 8);
        chk("short_pre", line_err, 0);
        drive_line(6, 0);
        @(negedge clk);
        chk("short_lerr", line_err, 1);
        wait_drain();
        do_reset();
        vs_frame(1);
        fill_rand(7); push_model(7, 8); drive_line(7, 0);
        @(negedge clk);
        chk("odd_lerr", line_err, 1);
        fill_rand(8); push_model(8, 8); drive_line(8, 0);
        @(negedge clk);
        chk("odd_done", frame_done, 1);
        wait_drain();

        // VSYNC rises after row 0: abort, idle, cap_en gating, restart.
        do_reset();
        fd0 = n_fd;
        vs_frame(1);
        fill_rand(8); push_model(8, 8); drive_line(8, 0);
        @(negedge clk); cam_vsync = 1'b1;
        repeat (4) @(negedge clk);
        chk("ab_ferr", frame_err, 1);
        wait_drain();
        fill_rand(8); drive_line(8, 0);
        repeat (6) @(negedge clk);
        chk("ab_idle", pix_valid, 0);
        chk("ab_nodone", n_fd - fd0, 0);
        vs_frame(0);
        fill_rand(8); drive_line(8, 0);
        repeat (6) @(negedge clk);
        chk("capen0_idle", pix_valid, 0);
        vs_frame(1);
        fill_rand(8); push_model(8, 8); drive_line(8, 0);
        fill_rand(8); push_model(8, 8); drive_line(8, 0);
        @(negedge clk);
        chk("ab_restart_done", frame_done, 1);
        wait_drain();

        // Random frames: random line lengths, bytes and ready pattern.
        for (int f = 0; f < 6; f++) begin
            int  nb;
            bit  err;
            rdy_mode = 1;
            do_reset();
            rdy_mode = 2;
            err = 1'b0;
            vs_frame(1);
            for (int r = 0; r < 2; r++) begin
                nb = $urandom_range(5, 9);
                if ((nb % 2) != 0 || (nb / 2) != 4) err = 1'b1;
                fill_rand(nb); push_model(nb, 8); drive_line(nb, 0);
                @(negedge clk);
                chk("rnd_done", frame_done, (r == 1));
            end
            wait_drain();
            chk("rnd_lerr", line_err, err);
            chk("rnd_ferr", {frame_err, overflow}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
